// File: rtl/uart_cmd_decoder.sv
// Parses HEADER/CMD/~CMD byte frames from the UART receiver into a registered
// 2-bit motor instruction, with an inter-byte gap timer and a command watchdog.
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [15:0] GAP_CYCLES  = 16'd5000,
  parameter logic [31:0] WDOG_CYCLES = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] instr,
  output logic       cmd_strobe,
  output logic       frame_err,
  output logic       timeout
);

  // state   | meaning
  // IDLE    | waiting for HEADER, other bytes dropped silently
  // GOT_HDR | HEADER seen, expecting CMD (upper six bits zero)
  // GOT_CMD | CMD latched in cmd_q, expecting CHK == ~cmd_q
  typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] gap_cnt;
  logic [31:0] wd_cnt;
  logic        accept, err, gap_expire, wd_expire;

  // The expiry cycle is the GAP_CYCLES-th idle cycle after the last byte.
  assign gap_expire = (GAP_CYCLES != 16'd0) && (state_q != IDLE) && !rx_valid &&
                      (gap_cnt == GAP_CYCLES - 16'd1);
  assign wd_expire  = (WDOG_CYCLES != 32'd0) && (wd_cnt == WDOG_CYCLES - 32'd1);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    accept  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data == HEADER) state_d = GOT_HDR;
      end
      GOT_HDR: begin
        if (rx_valid) begin
          if (rx_data[7:2] == 6'd0) begin
            cmd_d   = rx_data;
            state_d = GOT_CMD;
          end else begin
            err     = 1'b1;
            state_d = (rx_data == HEADER) ? GOT_HDR : IDLE;
          end
        end else if (gap_expire) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      GOT_CMD: begin
        if (rx_valid) begin
          if (rx_data == ~cmd_q) begin
            accept  = 1'b1;
            state_d = IDLE;
          end else begin
            err     = 1'b1;
            state_d = (rx_data == HEADER) ? GOT_HDR : IDLE;
          end
        end else if (gap_expire) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= 8'd0;
      gap_cnt    <= 16'd0;
      wd_cnt     <= 32'd0;
      instr      <= 2'b00;
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_strobe <= accept;
      frame_err  <= err;

      if (state_d == IDLE || rx_valid)
        gap_cnt <= 16'd0;
      else if (gap_cnt != 16'hFFFF)
        gap_cnt <= gap_cnt + 16'd1;

      if (accept)
        wd_cnt <= 32'd0;
      else if (wd_cnt != WDOG_CYCLES)
        wd_cnt <= wd_cnt + 32'd1;

      // Acceptance beats a coincident watchdog expiry.
      if (accept) begin
        instr   <= cmd_q[1:0];
        timeout <= 1'b0;
      end else if (wd_expire) begin
        instr   <= 2'b00;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: a byte/expectation table for framing,
// plus hand-written sequences for the gap timer, watchdog and reset cases.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [1:0] instr_a, instr_b, instr_c;
  logic       strobe_a, strobe_b, strobe_c;
  logic       err_a, err_b, err_c;
  logic       tmo_a, tmo_b, tmo_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder dut_a (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .instr(instr_a), .cmd_strobe(strobe_a), .frame_err(err_a), .timeout(tmo_a)
  );

  uart_cmd_decoder #(.GAP_CYCLES(16'd10), .WDOG_CYCLES(32'd0)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .instr(instr_b), .cmd_strobe(strobe_b), .frame_err(err_b), .timeout(tmo_b)
  );

  uart_cmd_decoder #(.GAP_CYCLES(16'd0), .WDOG_CYCLES(32'd50)) dut_c (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .instr(instr_c), .cmd_strobe(strobe_c), .frame_err(err_c), .timeout(tmo_c)
  );

  typedef struct {
    logic [7:0] data;
    logic       exp_strobe;
    logic       exp_err;
    logic [1:0] exp_instr;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int first;
    int pulses;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vecs[0]  = '{8'h33, 1'b0, 1'b0, 2'b00};
    vecs[1]  = '{8'hA5, 1'b0, 1'b0, 2'b00};
    vecs[2]  = '{8'h03, 1'b0, 1'b0, 2'b00};
    vecs[3]  = '{8'hFC, 1'b1, 1'b0, 2'b11};
    vecs[4]  = '{8'hA5, 1'b0, 1'b0, 2'b11};
    vecs[5]  = '{8'h02, 1'b0, 1'b0, 2'b11};
    vecs[6]  = '{8'h00, 1'b0, 1'b1, 2'b11};
    vecs[7]  = '{8'hA5, 1'b0, 1'b0, 2'b11};
    vecs[8]  = '{8'h01, 1'b0, 1'b0, 2'b11};
    vecs[9]  = '{8'hFE, 1'b1, 1'b0, 2'b01};
    vecs[10] = '{8'hA5, 1'b0, 1'b0, 2'b01};
    vecs[11] = '{8'hA5, 1'b0, 1'b1, 2'b01};
    vecs[12] = '{8'h02, 1'b0, 1'b0, 2'b01};
    vecs[13] = '{8'hFD, 1'b1, 1'b0, 2'b10};
    vecs[14] = '{8'hA5, 1'b0, 1'b0, 2'b10};
    vecs[15] = '{8'h44, 1'b0, 1'b1, 2'b10};
    vecs[16] = '{8'h03, 1'b0, 1'b0, 2'b10};
    vecs[17] = '{8'hFC, 1'b0, 1'b0, 2'b10};
    vecs[18] = '{8'hFD, 1'b0, 1'b0, 2'b10};

    do_reset();
    chk("reset_instr",   32'(instr_a),  32'd0);
    chk("reset_strobe",  32'(strobe_a), 32'd0);
    chk("reset_err",     32'(err_a),    32'd0);
    chk("reset_timeout", 32'(tmo_a),    32'd0);

    // Table: each byte followed by one idle cycle to confirm pulses are single-cycle.
    for (int i = 0; i < 19; i++) begin
      send(vecs[i].data);
      chk($sformatf("vec%0d_strobe", i), 32'(strobe_a), 32'(vecs[i].exp_strobe));
      chk($sformatf("vec%0d_err", i),    32'(err_a),    32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_instr", i),  32'(instr_a),  32'(vecs[i].exp_instr));
      tick();
      chk($sformatf("vec%0d_strobe_end", i), 32'(strobe_a), 32'd0);
      chk($sformatf("vec%0d_err_end", i),    32'(err_a),    32'd0);
    end

    // Reset mid-frame discards the partial frame.
    send(8'hA5);
    send(8'h03);
    reset = 1'b1;
    tick();
    chk("midreset_instr",  32'(instr_a),  32'd0);
    chk("midreset_strobe", 32'(strobe_a), 32'd0);
    tick();
    reset = 1'b0;
    send(8'hFC);
    chk("lone_chk_strobe", 32'(strobe_a), 32'd0);
    chk("lone_chk_err",    32'(err_a),    32'd0);
    chk("lone_chk_instr",  32'(instr_a),  32'd0);

    // Gap timer (GAP_CYCLES = 10) on dut_b.
    do_reset();
    send(8'hA5);
    send(8'h02);
    send(8'hFD);
    chk("gap_pre_instr", 32'(instr_b), 32'd2);
    send(8'hA5);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (err_b) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("gap_fire_cycle", 32'(first),  32'd10);
    chk("gap_pulses",     32'(pulses), 32'd1);
    send(8'h03);
    chk("gap_after_err1", 32'(err_b), 32'd0);
    send(8'hFC);
    chk("gap_after_strobe", 32'(strobe_b), 32'd0);
    chk("gap_after_err2",   32'(err_b),    32'd0);
    chk("gap_after_instr",  32'(instr_b),  32'd2);
    // Byte arriving on the expiry cycle is processed; timer does not fire.
    send(8'hA5);
    for (int i = 0; i < 9; i++) tick();
    send(8'h01);
    chk("gap_edge_err", 32'(err_b), 32'd0);
    send(8'hFE);
    chk("gap_edge_strobe", 32'(strobe_b), 32'd1);
    chk("gap_edge_instr",  32'(instr_b),  32'd1);

    // Watchdog (WDOG_CYCLES = 50) on dut_c.
    do_reset();
    send(8'hA5);
    send(8'h03);
    send(8'hFC);
    chk("wd_accept_instr", 32'(instr_c), 32'd3);
    first = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (tmo_c && first < 0) first = i;
    end
    chk("wd_fire_cycle",   32'(first),   32'd50);
    chk("wd_forced_instr", 32'(instr_c), 32'd0);
    chk("wd_timeout_held", 32'(tmo_c),   32'd1);
    send(8'hA5);
    send(8'h01);
    send(8'hFE);
    chk("wd_recover_strobe",  32'(strobe_c), 32'd1);
    chk("wd_recover_instr",   32'(instr_c),  32'd1);
    chk("wd_recover_timeout", 32'(tmo_c),    32'd0);
    // Acceptance on the expiry cycle wins.
    for (int i = 0; i < 47; i++) tick();
    send(8'hA5);
    send(8'h02);
    send(8'hFD);
    chk("wd_tie_strobe",  32'(strobe_c), 32'd1);
    chk("wd_tie_instr",   32'(instr_c),  32'd2);
    chk("wd_tie_timeout", 32'(tmo_c),    32'd0);
    for (int i = 0; i < 49; i++) tick();
    chk("wd_tie_still_ok", 32'(tmo_c), 32'd0);
    tick();
    chk("wd_tie_refire",       32'(tmo_c),   32'd1);
    chk("wd_tie_refire_instr", 32'(instr_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Sits between the UART receiver and motor_driver. Consumes the receiver's byte stream and parses 3-byte command frames: HEADER, CMD, CHK where CHK = ~CMD. It drives the registered 2-bit instr bus into motor_driver. A command watchdog forces the motor to stop (instr = 2'b00) if valid commands cease.

Parameters:
HEADER, 8'hA5, frame start byte.
GAP_CYCLES, 16'd5000, max clk cycles allowed between consecutive bytes inside a frame; 0 disables the gap check.
WDOG_CYCLES, 32'd5_000_000, clk cycles without an accepted command before forced stop; 0 disables the watchdog.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte, qualified by rx_valid
rx_valid  input  1  one-cycle strobe, byte present on rx_data
instr  output  2  registered motor instruction to motor_driver
cmd_strobe  output  1  one-cycle pulse, frame accepted and instr updated
frame_err  output  1  one-cycle pulse, frame rejected
timeout  output  1  level, watchdog has expired and instr is forced to 00

Behaviour:
- One clock, clk. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: instr = 2'b00, cmd_strobe = 0, frame_err = 0, timeout = 0, FSM = IDLE, all counters = 0.
- FSM states: IDLE, GOT_HDR, GOT_CMD. A register cmd_q[7:0] holds the CMD byte.
- IDLE:
  - rx_valid with rx_data == HEADER -> GOT_HDR.
  - Any other byte is ignored silently; no frame_err.
- GOT_HDR, on rx_valid:
  - If rx_data[7:2] == 0: latch cmd_q, go to GOT_CMD.
  - Otherwise pulse frame_err. Go to GOT_HDR if the byte == HEADER (resync), else go to IDLE.
- GOT_CMD, on rx_valid:
  - If rx_data == ~cmd_q: accept the frame. On the next edge, instr <= cmd_q[1:0], cmd_strobe = 1 for exactly one cycle, timeout <= 0. FSM -> IDLE.
  - Otherwise pulse frame_err. Go to GOT_HDR if the byte == HEADER, else go to IDLE.
- Latency: instr and cmd_strobe change on the edge that samples the CHK byte, so both are visible the cycle after CHK's rx_valid. frame_err also appears the cycle after the offending byte.
- Gap timer:
  - Counts cycles while in GOT_HDR or GOT_CMD. Clears on every rx_valid and on entry to IDLE.
  - Reaching GAP_CYCLES with no byte pulses frame_err and returns to IDLE.
  - If rx_valid arrives on the same cycle the timer expires, the byte is processed and the timer does not fire.
- Watchdog:
  - Counts every cycle. Clears on frame acceptance; saturates at WDOG_CYCLES.
  - On the cycle the count reaches WDOG_CYCLES, the next edge sets instr <= 2'b00 and timeout <= 1. timeout holds until the next accepted frame.
  - If acceptance and expiry coincide, acceptance wins: instr takes the new command, timeout = 0, counter = 0.
  - Frame parsing continues normally while timeout = 1.
- Only one of cmd_strobe and frame_err can pulse in any cycle.
- Reset mid-frame discards the partial frame: FSM -> IDLE, instr -> 00.
- Counters are wide enough for their parameter and never wrap.

Test Plan:
- Reset, then bytes A5, 03, FC -> cmd_strobe pulses once the cycle after FC; instr = 2'b11; frame_err stays 0.
- A5, 02, 00 (bad CHK) -> frame_err pulses once; instr unchanged from the prior 2'b11; FSM back in IDLE. Then A5, 01, FE -> instr = 2'b01.
- A5, A5, 02, FD (header repeated) -> frame_err pulses on the second A5, FSM resyncs to GOT_HDR, the frame is accepted, instr = 2'b10.
- GAP_CYCLES = 10: send A5, then idle 10 cycles -> frame_err pulses, FSM returns to IDLE. A later 03, FC alone is ignored; instr unchanged.
- WDOG_CYCLES = 50: accept 03 -> instr = 11. After 50 idle cycles -> instr = 00, timeout = 1. Then A5, 01, FE -> instr = 01, timeout = 0.
- Assert reset right after A5, 03 -> instr = 00, no strobe. After release, a lone FC produces no response.
